// File: rtl/cpu_pkg.sv
// cpu_pkg: shared pipeline widths, fetch constants and the pending-redirect state type.
package cpu_pkg;
  localparam int PC_WIDTH = 32;
  localparam int INSTR_WIDTH = 32;
  localparam logic [INSTR_WIDTH-1:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [PC_WIDTH-1:0] RESET_PC = 32'h0000_0000;
  typedef enum logic {IDLE, HELD} pend_state_t;
  function automatic logic [PC_WIDTH-1:0] align(input logic [PC_WIDTH-1:0] a);
    return {a[PC_WIDTH-1:2], 2'b00};
  endfunction
endpackage

// File: rtl/if_redirect_hold.sv
// if_redirect_hold: holds a redirect that arrives during a stall and replays it on release.
module if_redirect_hold
  import cpu_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                stall,
  input  logic                redirect_valid,
  input  logic [PC_WIDTH-1:0] redirect_pc,
  output logic                eff_redirect_valid,
  output logic [PC_WIDTH-1:0] eff_redirect_pc
);
  pend_state_t state, state_next;
  logic [PC_WIDTH-1:0] target;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      target <= '0;
    end else begin
      state <= state_next;
      if (stall && redirect_valid) target <= align(redirect_pc);
    end
  end
  always_comb state_next = (stall && (redirect_valid || state == HELD)) ? HELD : IDLE;
  // A live redirect always beats the stored one.
  always_comb begin
    eff_redirect_valid = !stall && (redirect_valid || state == HELD);
    eff_redirect_pc = redirect_valid ? align(redirect_pc) : target;
  end
endmodule

// File: rtl/if_fetch_stage.sv
// if_fetch_stage: PC, sequential fetch and IF/ID register with stall, flush and redirects.
// Define IF_PERF_CNT_EN to add fetch_count and stall_count outputs.
module if_fetch_stage #(
  parameter logic [cpu_pkg::PC_WIDTH-1:0]    RESET_PC  = cpu_pkg::RESET_PC,
  parameter logic [cpu_pkg::INSTR_WIDTH-1:0] NOP_INSTR = cpu_pkg::NOP_INSTR
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            stall,
  input  logic                            flush,
  input  logic                            redirect_valid,
  input  logic [cpu_pkg::PC_WIDTH-1:0]    redirect_pc,
  output logic [cpu_pkg::PC_WIDTH-1:0]    rom_addr,
  input  logic [cpu_pkg::INSTR_WIDTH-1:0] rom_data,
  output logic [cpu_pkg::INSTR_WIDTH-1:0] if_id_instr,
  output logic [cpu_pkg::PC_WIDTH-1:0]    if_id_pc_plus4,
  output logic                            if_id_valid,
`ifdef IF_PERF_CNT_EN
  output logic [31:0]                     fetch_count,
  output logic [31:0]                     stall_count,
`endif
  output logic [cpu_pkg::PC_WIDTH-1:0]    pc
);
  logic                         eff_redirect_valid;
  logic [cpu_pkg::PC_WIDTH-1:0] eff_redirect_pc;
  logic [cpu_pkg::PC_WIDTH-1:0] pc_plus4;
  if_redirect_hold u_hold (
    .clk(clk),
    .reset(reset),
    .stall(stall),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .eff_redirect_valid(eff_redirect_valid),
    .eff_redirect_pc(eff_redirect_pc)
  );
  assign rom_addr = pc;
  assign pc_plus4 = pc + 32'd4;
  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= RESET_PC;
      if_id_instr <= NOP_INSTR;
      if_id_pc_plus4 <= '0;
      if_id_valid <= 1'b0;
    end else if (eff_redirect_valid) begin
      pc <= eff_redirect_pc;
      if_id_instr <= NOP_INSTR;
      if_id_pc_plus4 <= '0;
      if_id_valid <= 1'b0;
    end else if (!stall) begin
      pc <= pc_plus4;
      if_id_instr <= flush ? NOP_INSTR : rom_data;
      if_id_pc_plus4 <= flush ? '0 : pc_plus4;
      if_id_valid <= !flush;
    end
  end
`ifdef IF_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_count <= '0;
      stall_count <= '0;
    end else begin
      if (!stall && !eff_redirect_valid && !flush) fetch_count <= fetch_count + 32'd1;
      if (stall) stall_count <= stall_count + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_if_fetch_stage.sv
// tb_if_fetch_stage: directed plan plus random traffic against a priority-list reference model.
module tb_if_fetch_stage;
  logic clk = 1'b0, reset = 1'b0, stall = 1'b0, flush = 1'b0, redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0, rom_addr, rom_data, if_id_instr, if_id_pc_plus4, pc;
  logic if_id_valid;
`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_count, stall_count;
`endif
  int n_cmp = 0, n_err = 0;
  logic [31:0] m_pc, m_instr, m_p4, m_ppc, m_fc, m_sc;
  logic m_valid, m_pend;

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hBEEF, a[15:0]};
  endfunction
  assign rom_data = rom_word(rom_addr);

  if_fetch_stage dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .if_id_instr(if_id_instr), .if_id_pc_plus4(if_id_pc_plus4), .if_id_valid(if_id_valid),
`ifdef IF_PERF_CNT_EN
    .fetch_count(fetch_count), .stall_count(stall_count),
`endif
    .pc(pc)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock: apply inputs, advance the reference model, compare every output.
  task automatic step(input string tag, input logic r, input logic s, input logic f,
                      input logic rv, input logic [31:0] rpc);
    reset = r; stall = s; flush = f; redirect_valid = rv; redirect_pc = rpc;
    @(posedge clk);
    if (r) begin
      m_pc = 32'h0; m_instr = 32'h0; m_p4 = 32'h0; m_valid = 0; m_pend = 0; m_fc = 0; m_sc = 0;
    end else begin
      if (s) m_sc++;
      if (rv && !s) begin
        m_pc = rpc & ~32'h3; m_instr = 0; m_p4 = 0; m_valid = 0; m_pend = 0;
      end else if (!s && m_pend) begin
        m_pc = m_ppc; m_instr = 0; m_p4 = 0; m_valid = 0; m_pend = 0;
      end else if (s) begin
        if (rv) begin m_pend = 1; m_ppc = rpc & ~32'h3; end
      end else if (f) begin
        m_pc = m_pc + 4; m_instr = 0; m_p4 = 0; m_valid = 0;
      end else begin
        m_instr = rom_word(m_pc); m_p4 = m_pc + 4; m_valid = 1; m_pc = m_pc + 4; m_fc++;
      end
    end
    #1;
    chk({tag, ".pc"}, pc, m_pc);
    chk({tag, ".rom_addr"}, rom_addr, m_pc);
    chk({tag, ".instr"}, if_id_instr, m_instr);
    chk({tag, ".pc4"}, if_id_pc_plus4, m_p4);
    chk({tag, ".valid"}, {31'b0, if_id_valid}, {31'b0, m_valid});
`ifdef IF_PERF_CNT_EN
    chk({tag, ".fcnt"}, fetch_count, m_fc);
    chk({tag, ".scnt"}, stall_count, m_sc);
`endif
  endtask

  initial begin
    m_pc = 0; m_instr = 0; m_p4 = 0; m_ppc = 0; m_fc = 0; m_sc = 0; m_valid = 0; m_pend = 0;
    step("rst", 1, 0, 0, 0, 0);
    chk("rst_pc", pc, 32'h0);
    for (int i = 0; i < 4; i++) step("run", 0, 0, 0, 0, 0);
    chk("run_pc", pc, 32'h10);
    chk("run_p4", if_id_pc_plus4, 32'h10);
    step("redir", 0, 0, 0, 1, 32'h48);
    chk("redir_pc", pc, 32'h48);
    chk("redir_bubble", {31'b0, if_id_valid}, 32'h0);
    step("after_redir", 0, 0, 0, 0, 0);
    chk("tgt_instr", if_id_instr, rom_word(32'h48));
    chk("tgt_p4", if_id_pc_plus4, 32'h4C);
    step("to20", 0, 0, 0, 1, 32'h20);
    step("stall1", 0, 1, 0, 1, 32'h4C);
    step("stall2", 0, 1, 0, 1, 32'h50);
    step("stall3", 0, 1, 0, 0, 0);
    chk("stall_hold", pc, 32'h20);
    step("release", 0, 0, 0, 0, 0);
    chk("pend_pc", pc, 32'h50);
    step("to08", 0, 0, 0, 1, 32'h08);
    step("flush", 0, 0, 1, 0, 0);
    chk("flush_pc", pc, 32'h0C);
    step("norm", 0, 0, 0, 0, 0);
    step("flush_stall", 0, 1, 1, 0, 0);
    chk("fs_pc", pc, 32'h10);
    chk("fs_valid", {31'b0, if_id_valid}, 32'h1);
    step("pend80", 0, 1, 0, 1, 32'h80);
    step("rst_mid", 1, 1, 0, 0, 0);
    step("post_rst", 0, 0, 0, 0, 0);
    chk("no_stale", pc, 32'h4);
    step("align", 0, 0, 0, 1, 32'h33);
    chk("align_pc", pc, 32'h30);
    step("wrap", 0, 0, 0, 1, 32'hFFFF_FFFC);
    step("wrap2", 0, 0, 0, 0, 0);
    chk("wrap_pc", pc, 32'h0);
    step("prst", 1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step("pf", 0, 0, 0, 0, 0);
    for (int i = 0; i < 2; i++) step("ps", 0, 1, 0, 0, 0);
`ifdef IF_PERF_CNT_EN
    chk("fcnt5", fetch_count, 32'd5);
    chk("scnt2", stall_count, 32'd2);
`endif
    for (int i = 0; i < 500; i++)
      step("rnd", $urandom_range(99) < 2, $urandom_range(99) < 30, $urandom_range(99) < 10,
           $urandom_range(99) < 15, $urandom);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
